// File: rtl/steer_pkg.sv
// Shared steering-encoder definitions: APB register map, field positions and the
// quadrature step decoder used by both the encoder block and the steering controller.
package steer_pkg;

  localparam int SAMPLE_DIV_DEF = 100000;

  localparam logic [7:0] OFF_POS    = 8'h00;
  localparam logic [7:0] OFF_VEL    = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;

  localparam logic [1:0] REG_POS    = OFF_POS[3:2];
  localparam logic [1:0] REG_VEL    = OFF_VEL[3:2];
  localparam logic [1:0] REG_STATUS = OFF_STATUS[3:2];
  localparam logic [1:0] REG_CTRL   = OFF_CTRL[3:2];

  localparam int STATUS_ERR_BIT = 0;
  localparam int STATUS_SAT_BIT = 1;
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_INV_BIT   = 1;

  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILL} step_e;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [1:0] idx;
  } apb_dec_t;

  // {A,B} Gray order 00 -> 01 -> 11 -> 10 -> 00 is forward
  function automatic step_e gray_step(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return STEP_FWD;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: return STEP_REV;
      4'b0000, 4'b0101, 4'b1111, 4'b1010: return STEP_NONE;
      default:                            return STEP_ILL;
    endcase
  endfunction

endpackage

// File: rtl/enc_filter.sv
// One encoder channel: 2-FF synchronizer followed by a run-length filter that
// accepts a level only after FILT_LEN consecutive equal samples.
module enc_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic enc,
  output logic lvl,
  output logic vld
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          done;

  assign cnt_inc = cnt + CW'(1);
  assign done    = (cnt_inc == CW'(FILT_LEN));

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      sync_q <= '0;
      lvl    <= 1'b0;
      vld    <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], enc};
      if (!vld) begin
        // before the first acceptance lvl is only a candidate; a differing sample restarts the run
        if (sync_q[1] != lvl) begin
          lvl <= sync_q[1];
          cnt <= (FILT_LEN == 1) ? '0 : CW'(1);
          if (FILT_LEN == 1) vld <= 1'b1;
        end else if (done) begin
          vld <= 1'b1;
          cnt <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end else if (sync_q[1] != lvl) begin
        if (done) begin
          lvl <= sync_q[1];
          cnt <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/steer_encoder.sv
// Steering shaft quadrature encoder: filtered Gray decode into a saturating position,
// windowed velocity sampling with SAMPLEINT, and an APB register interface.
module steer_encoder
  import steer_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int FILT_LEN   = 3,
  parameter int POS_MAX    = 1023
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        ENC_A,
  input  logic        ENC_B,
  output logic        SAMPLEINT
);

  localparam int NUM_CH = 2;
  localparam int WCW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [WCW-1:0]    WIN_LAST = WCW'(SAMPLE_DIV - 1);
  localparam logic signed [10:0] POS_HI  = 11'(POS_MAX);
  localparam logic signed [10:0] POS_LO  = 11'(-POS_MAX - 1);

  logic [NUM_CH-1:0] enc_raw, f_lvl, f_vld;
  logic [1:0]        prev_ab;
  logic              ref_vld;

  logic signed [10:0] pos;
  logic signed [15:0] acc, acc_base, acc_nx, vel;
  logic [WCW-1:0]     win_cnt;
  logic               win_end;
  logic               err, sat, ctrl_en, ctrl_inv;

  step_e    st;
  apb_dec_t dec;
  logic     pos_wr, stat_wr, ctrl_wr;
  logic     fwd, rev, ill, up, dn, sat_set;
  logic     unused;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign unused  = ^{PADDR[1:0], PWDATA[31:11]};

  // bit 1 = A, bit 0 = B, so f_lvl is the {A,B} Gray state
  assign enc_raw = {ENC_A, ENC_B};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    enc_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .PCLK    (PCLK),
      .PRESETN (PRESETN),
      .enc     (enc_raw[ch]),
      .lvl     (f_lvl[ch]),
      .vld     (f_vld[ch])
    );
  end

  assign dec.wr  = PSEL && PENABLE && PWRITE && (PADDR[7:4] == 4'h0);
  assign dec.rd  = PSEL && !PWRITE && (PADDR[7:4] == 4'h0);
  assign dec.idx = PADDR[3:2];
  assign pos_wr  = dec.wr && (dec.idx == REG_POS);
  assign stat_wr = dec.wr && (dec.idx == REG_STATUS);
  assign ctrl_wr = dec.wr && (dec.idx == REG_CTRL);

  assign st      = gray_step(prev_ab, f_lvl);
  assign fwd     = ref_vld && (st == STEP_FWD);
  assign rev     = ref_vld && (st == STEP_REV);
  assign ill     = ref_vld && (st == STEP_ILL);
  assign up      = ctrl_en && !pos_wr && (ctrl_inv ? rev : fwd);
  assign dn      = ctrl_en && !pos_wr && (ctrl_inv ? fwd : rev);
  assign sat_set = (up && pos >= POS_HI) || (dn && pos <= POS_LO);
  assign win_end = (win_cnt == WIN_LAST);

  // a step landing on the window-end cycle seeds the new window
  always_comb begin
    acc_base = win_end ? '0 : acc;
    acc_nx   = acc_base;
    if (up && acc_base != 16'sh7FFF)      acc_nx = acc_base + 16'sd1;
    else if (dn && acc_base != 16'sh8000) acc_nx = acc_base - 16'sd1;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      prev_ab   <= '0;
      ref_vld   <= 1'b0;
      pos       <= '0;
      acc       <= '0;
      vel       <= '0;
      win_cnt   <= '0;
      SAMPLEINT <= 1'b0;
      err       <= 1'b0;
      sat       <= 1'b0;
      ctrl_en   <= 1'b0;
      ctrl_inv  <= 1'b0;
    end else begin
      // the first state where both channels are accepted becomes the reference, never a step
      if (ref_vld || (&f_vld)) begin
        prev_ab <= f_lvl;
        ref_vld <= 1'b1;
      end

      if (pos_wr)  pos <= $signed(PWDATA[10:0]);
      else if (up) pos <= (pos >= POS_HI) ? POS_HI : pos + 11'sd1;
      else if (dn) pos <= (pos <= POS_LO) ? POS_LO : pos - 11'sd1;

      acc       <= acc_nx;
      SAMPLEINT <= win_end;
      if (win_end) begin
        vel     <= acc;
        win_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + WCW'(1);
      end

      err <= ill     | (err & ~(stat_wr & PWDATA[STATUS_ERR_BIT]));
      sat <= sat_set | (sat & ~(stat_wr & PWDATA[STATUS_SAT_BIT]));
      if (ctrl_wr) begin
        ctrl_en  <= PWDATA[CTRL_EN_BIT];
        ctrl_inv <= PWDATA[CTRL_INV_BIT];
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (dec.rd) begin
      case (dec.idx)
        REG_POS:    PRDATA = {{21{pos[10]}}, pos};
        REG_VEL:    PRDATA = {{16{vel[15]}}, vel};
        REG_STATUS: PRDATA = {30'b0, sat, err};
        REG_CTRL:   PRDATA = {30'b0, ctrl_inv, ctrl_en};
        default:    PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_steer_encoder.sv
// Bench for steer_encoder: directed encoder/APB stimulus, a history-based reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_steer_encoder;
  import steer_pkg::*;

  localparam int SDIV = 1000;
  localparam int FL   = 3;
  localparam int PMAX = 1023;

  logic        PCLK = 0, PRESETN = 0;
  logic        PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, SAMPLEINT;
  logic        ENC_A = 0, ENC_B = 0;

  always #5 PCLK = ~PCLK;

  steer_encoder #(.SAMPLE_DIV(SDIV), .FILT_LEN(FL), .POS_MAX(PMAX)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .ENC_A(ENC_A), .ENC_B(ENC_B), .SAMPLEINT(SAMPLEINT)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_pos, m_vel, m_acc, m_wcnt, m_ns, m_st, m_dd;
  bit       m_err, m_sat, m_en, m_inv, m_si, m_ref, m_ill, m_pw, m_satset, m_eq;
  bit [1:0] m_d1, m_d2, m_flvl, m_fvld, m_prev, m_clr;
  bit       m_hist [2][FL];
  int       m_gidx [4] = '{0, 1, 3, 2};

  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      m_pos = 0; m_vel = 0; m_acc = 0; m_wcnt = 0; m_ns = 0;
      m_err = 0; m_sat = 0; m_en = 0; m_inv = 0; m_si = 0; m_ref = 0;
      m_d1 = 0; m_d2 = 0; m_flvl = 0; m_fvld = 0; m_prev = 0;
      for (int c = 0; c < 2; c++) for (int k = 0; k < FL; k++) m_hist[c][k] = 0;
    end else begin
      m_st = 0; m_ill = 0;
      if (m_ref) begin
        m_dd = (m_gidx[m_flvl] - m_gidx[m_prev] + 4) % 4;
        if (m_dd == 1) m_st = 1;
        else if (m_dd == 3) m_st = -1;
        else if (m_dd == 2) m_ill = 1;
      end
      if (!m_en) m_st = 0;
      else if (m_inv) m_st = -m_st;
      m_pw = 0; m_clr = 0; m_satset = 0;
      if (PSEL && PENABLE && PWRITE && PADDR[7:4] == 0) begin
        case (PADDR[3:2])
          2'd0: begin m_pos = int'($signed(PWDATA[10:0])); m_pw = 1; m_st = 0; end
          2'd2: m_clr = PWDATA[1:0];
          2'd3: begin m_en = PWDATA[0]; m_inv = PWDATA[1]; end
          default: ;
        endcase
      end
      if (!m_pw && m_st != 0) begin
        if (m_pos + m_st > PMAX)           begin m_pos = PMAX;      m_satset = 1; end
        else if (m_pos + m_st < -PMAX - 1) begin m_pos = -PMAX - 1; m_satset = 1; end
        else m_pos = m_pos + m_st;
      end
      m_err = m_ill | (m_err & !m_clr[0]);
      m_sat = m_satset | (m_sat & !m_clr[1]);
      if (m_wcnt == SDIV - 1) begin
        m_vel = m_acc; m_acc = 0; m_wcnt = 0; m_si = 1;
      end else begin
        m_wcnt++; m_si = 0;
      end
      m_acc = m_acc + m_st;
      if (m_acc > 32767) m_acc = 32767;
      if (m_acc < -32768) m_acc = -32768;
      if (m_ref) m_prev = m_flvl;
      else if (&m_fvld) begin m_ref = 1; m_prev = m_flvl; end
      // filter: level accepted once the last FL synchronized samples agree
      if (m_ns < 1000) m_ns++;
      for (int c = 0; c < 2; c++) begin
        for (int k = FL - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = m_d2[c];
        m_eq = 1;
        for (int k = 1; k < FL; k++) if (m_hist[c][k] != m_hist[c][0]) m_eq = 0;
        if (m_ns >= FL && m_eq) begin m_fvld[c] = 1; m_flvl[c] = m_hist[c][0]; end
      end
      m_d2 = m_d1;
      m_d1 = {ENC_A, ENC_B};
    end
  end

  function automatic logic [31:0] m_rd();
    if (!(PSEL && !PWRITE && PADDR[7:4] == 0)) return 32'h0;
    case (PADDR[3:2])
      2'd0:    return 32'(m_pos);
      2'd1:    return 32'(m_vel);
      2'd2:    return {30'b0, m_sat, m_err};
      default: return {30'b0, m_inv, m_en};
    endcase
  endfunction

  always @(negedge PCLK) begin
    chk("sampleint", SAMPLEINT, m_si);
    chk("pready_pslverr", {PREADY, PSLVERR}, 2'b10);
    chk("prdata", PRDATA, m_rd());
  end

  // ---------------- stimulus ----------------
  logic [1:0] ab_now = 2'b00;
  logic [31:0] rdat;
  int k_si;

  function automatic logic [1:0] nxt(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1;
    tick();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] want);
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
    tick();
    PENABLE = 1;
    @(negedge PCLK);
    rdat = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
    chk(nm, rdat, want);
  endtask

  task automatic fwd(input int n);
    repeat (n) begin
      ab_now = nxt(ab_now);
      {ENC_A, ENC_B} = ab_now;
      tick(10);
    end
  endtask

  task automatic wait_si(input int lim, output int k);
    k = 0;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (SAMPLEINT) begin k = i; break; end
    end
  endtask

  initial begin
    tick(3);
    PRESETN = 1;
    chk("rst_sampleint", SAMPLEINT, 0);
    rd_chk("rst_pos", OFF_POS, 0);
    rd_chk("rst_vel", OFF_VEL, 0);
    rd_chk("rst_status", OFF_STATUS, 0);
    rd_chk("rst_ctrl", OFF_CTRL, 0);
    rd_chk("unmapped", 8'h10, 0);
    tick(10);

    apb_wr(OFF_CTRL, 32'h1);
    rd_chk("ctrl_en", OFF_CTRL, 32'h1);
    fwd(8); tick(10);
    rd_chk("fwd8_pos", OFF_POS, 32'd8);
    rd_chk("fwd8_status", OFF_STATUS, 0);

    apb_wr(OFF_POS, 0); apb_wr(OFF_CTRL, 32'h3);
    fwd(8); tick(10);
    rd_chk("inv8_pos", OFF_POS, 32'hFFFF_FFF8);

    apb_wr(OFF_CTRL, 32'h1); apb_wr(OFF_POS, 0);
    ENC_A = 1; tick(2); ENC_A = 0; tick(10);
    rd_chk("glitch_pos", OFF_POS, 0);
    rd_chk("glitch_status", OFF_STATUS, 0);
    ab_now = 2'b11; {ENC_A, ENC_B} = ab_now; tick(10);
    rd_chk("illegal_pos", OFF_POS, 0);
    rd_chk("illegal_err", OFF_STATUS, 32'h1);
    apb_wr(OFF_STATUS, 32'h1);
    rd_chk("w1c_err", OFF_STATUS, 0);

    apb_wr(OFF_POS, 32'd1020);
    fwd(6); tick(5);
    rd_chk("sat_pos", OFF_POS, 32'd1023);
    rd_chk("sat_status", OFF_STATUS, 32'h2);
    apb_wr(OFF_STATUS, 32'h2);
    // step is accepted FL+3 edges after the input change, the same edge as this write
    ab_now = nxt(ab_now); {ENC_A, ENC_B} = ab_now;
    tick(4);
    apb_wr(OFF_POS, 32'd100);
    tick(10);
    rd_chk("wr_prio_pos", OFF_POS, 32'd100);
    rd_chk("sat_cleared", OFF_STATUS, 0);

    wait_si(SDIV + 100, k_si); chk("si_seen_a", k_si > 0, 1);
    fwd(5);
    wait_si(SDIV + 100, k_si); chk("si_seen_b", k_si > 0, 1);
    rd_chk("vel5", OFF_VEL, 32'd5);
    wait_si(SDIV + 100, k_si); chk("si_seen_c", k_si > 0, 1);
    rd_chk("vel0", OFF_VEL, 0);

    apb_wr(OFF_POS, 32'd37);
    rd_chk("pos37", OFF_POS, 32'd37);
    wait_si(SDIV + 100, k_si);
    tick(300);
    PRESETN = 0;
    #1 PSEL = 1; PWRITE = 0;
    for (int a = 0; a < 4; a++) begin
      PADDR = 8'(a * 4);
      #0.5 chk("midrst_reg", PRDATA, 0);
    end
    chk("midrst_si", SAMPLEINT, 0);
    PSEL = 0;
    tick(3);
    PRESETN = 1;
    wait_si(SDIV + 100, k_si);
    chk("si_after_rst", k_si, SDIV);
    rd_chk("post_rst_pos", OFF_POS, 0);
    rd_chk("post_rst_status", OFF_STATUS, 0);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
